alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (>=8, power of two).
REQ-002 SHALL have parameter SEL_WIDTH, default 4, opcode width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  request; sampled only when busy=0.
REQ-007 Port: op_sel  input  SEL_WIDTH  operation code.
REQ-008 Port: operand1, operand2  input  DATA_WIDTH each  signed operands.
REQ-009 Port: busy  output  1  iterative operation in progress.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: result  output  DATA_WIDTH  registered result.
REQ-012 Port: hi, lo  output  DATA_WIDTH each  mul/div result registers.
REQ-013 Port: zero, overflow, div_zero  output  1 each  status flags.

Function
REQ-014 Opcodes SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, XOR 0101, NOR 0110, SLL 0111, SRL 1000, SGT 1001, MULT 1010, MULTU 1011, DIV 1100, DIVU 1101; others undefined.
REQ-015 FSM states SHALL be IDLE, MUL, DIV; IDLE->MUL on start with MULT/MULTU, IDLE->DIV on start with DIV/DIVU and operand2!=0, MUL/DIV->IDLE after DATA_WIDTH iterations.
REQ-016 Operands and opcode SHALL be latched at start acceptance; input changes while busy ignored.
REQ-017 start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-018 Single-cycle ops (0000-1001, undefined): start accepted at edge N -> result/flags updated and done=1 in cycle N+1; busy stays 0.
REQ-019 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; overflow=1 on signed overflow, else 0.
REQ-020 SLT/SGT SHALL compare signed, result 1 or 0; SLL/SRL SHALL shift operand2 by operand1 modulo DATA_WIDTH, zero fill.
REQ-021 Undefined opcode SHALL give result 0, zero=1, overflow 0.
REQ-022 MULT/MULTU: shift-add, one bit per cycle; busy=1 cycles N+1..N+DATA_WIDTH; done=1, busy=0 in cycle N+DATA_WIDTH+1; {hi,lo}=2*DATA_WIDTH product (signed/unsigned); result=lo; overflow 0.
REQ-023 DIV/DIVU: restoring, same latency as REQ-022; lo=quotient, hi=remainder, result=lo; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-024 DIV of most-negative value by -1 SHALL give lo=most-negative, hi=0, overflow=1.
REQ-025 Divide by zero SHALL complete single-cycle: div_zero=1, lo=all ones, hi=operand1, result=lo; div_zero=0 on every other completion.
REQ-026 zero SHALL equal (result==0), updated only at done.
REQ-027 result, flags SHALL hold between done pulses; hi/lo change only on mul/div completion.
REQ-028 start SHALL be accepted in the done cycle (busy=0), back-to-back.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and busy, done, result, hi, lo, zero, overflow, div_zero to 0, aborting any operation without a done pulse.
REQ-030 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (DATA_WIDTH=32)
REQ-031 ADD 0x7FFFFFFF,0x00000001 -> cycle N+1: done=1, result 0x80000000, overflow 1, zero 0.
REQ-032 MULT 0xFFFFFFFD(-3),5 -> busy 32 cycles, done N+33: hi 0xFFFFFFFF, lo 0xFFFFFFF1, result 0xFFFFFFF1.
REQ-033 DIVU 100,7 -> done N+33: lo 14, hi 2; DIV 0xFFFFFFF9(-7),2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF.
REQ-034 DIV 5,0 -> done N+1: div_zero 1, lo 0xFFFFFFFF, hi 5; DIV 0x80000000,0xFFFFFFFF -> lo 0x80000000, hi 0, overflow 1.
REQ-035 MULTU started, ADD start at N+5 ignored (hi/lo/result unchanged by it); rst_n low at N+10 -> busy 0 and all outputs 0 immediately, no done afterwards.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus iterative multiply / divide unit.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : request, sampled only while busy=0
//   op_sel               : operation code
//   operand1, operand2   : operands (signed or unsigned depending on op)
//   busy                 : shift-add multiply or restoring divide in progress
//   done                 : one-cycle completion pulse
//   result               : registered result
//   hi, lo               : mul/div result registers ({hi,lo} product, or
//                          remainder/quotient)
//   zero, overflow,
//   div_zero             : status flags, updated only on completion
//
// Single-cycle ops complete at the accepting edge. MULT/MULTU/DIV/DIVU take
// DATA_WIDTH iterations, one bit per cycle, and work on operand magnitudes;
// the sign is re-applied on the final iteration.
module alu_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  op_sel,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  zero,
    output logic                  overflow,
    output logic                  div_zero
);

    localparam int DW = DATA_WIDTH;
    localparam int SH = $clog2(DW);
    localparam int CW = $clog2(DW);

    localparam logic [SEL_WIDTH-1:0] OP_ADD   = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] OP_SUB   = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] OP_AND   = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] OP_OR    = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] OP_SLT   = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] OP_XOR   = SEL_WIDTH'(5);
    localparam logic [SEL_WIDTH-1:0] OP_NOR   = SEL_WIDTH'(6);
    localparam logic [SEL_WIDTH-1:0] OP_SLL   = SEL_WIDTH'(7);
    localparam logic [SEL_WIDTH-1:0] OP_SRL   = SEL_WIDTH'(8);
    localparam logic [SEL_WIDTH-1:0] OP_SGT   = SEL_WIDTH'(9);
    localparam logic [SEL_WIDTH-1:0] OP_MULT  = SEL_WIDTH'(10);
    localparam logic [SEL_WIDTH-1:0] OP_MULTU = SEL_WIDTH'(11);
    localparam logic [SEL_WIDTH-1:0] OP_DIV   = SEL_WIDTH'(12);
    localparam logic [SEL_WIDTH-1:0] OP_DIVU  = SEL_WIDTH'(13);

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   a_q;      // product high half / partial remainder
    logic [DW-1:0]   b_q;      // multiplier-then-product low half / quotient
    logic [DW-1:0]   m_q;      // multiplicand / divisor magnitude
    logic            neg_q;    // negate product or quotient at the end
    logic            rneg_q;   // negate remainder at the end
    logic            ovf_q;    // most-negative / -1 division

    logic            is_mul, is_div, is_sgn, last;
    logic [DW-1:0]   alu_res;
    logic            alu_ovf;
    logic [DW-1:0]   sum, diff;
    logic [DW:0]     msum, rsh, rsub;
    logic [DW-1:0]   mul_a, mul_b, div_a, div_b;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   quo, rem;

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic s);
        return (s && v[DW-1]) ? -v : v;
    endfunction

    assign is_mul = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
    assign is_div = (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
    assign is_sgn = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign last   = (cnt_q == CW'(DW-1));
    assign busy   = (state_q != IDLE);

    // Single-cycle ALU
    assign sum  = operand1 + operand2;
    assign diff = operand1 - operand2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (operand1[DW-1] == operand2[DW-1]) && (sum[DW-1] != operand1[DW-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (operand1[DW-1] != operand2[DW-1]) && (diff[DW-1] != operand1[DW-1]);
            end
            OP_AND: alu_res = operand1 & operand2;
            OP_OR:  alu_res = operand1 | operand2;
            OP_XOR: alu_res = operand1 ^ operand2;
            OP_NOR: alu_res = ~(operand1 | operand2);
            OP_SLT: alu_res[0] = ($signed(operand1) < $signed(operand2));
            OP_SGT: alu_res[0] = ($signed(operand1) > $signed(operand2));
            OP_SLL: alu_res = operand2 << operand1[SH-1:0];
            OP_SRL: alu_res = operand2 >> operand1[SH-1:0];
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand when multiplier LSB is set, then
    // shift the {a,b} pair right one place.
    assign msum  = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
    assign mul_a = msum[DW:1];
    assign mul_b = {msum[0], b_q[DW-1:1]};
    assign prod  = neg_q ? -{mul_a, mul_b} : {mul_a, mul_b};

    // Restoring step: shift next dividend bit into the remainder, subtract
    // the divisor if it fits. Remainder stays below the divisor, so DW bits hold it.
    assign rsh  = {a_q, b_q[DW-1]};
    assign rsub = rsh - {1'b0, m_q};

    always_comb begin
        if (rsh >= {1'b0, m_q}) begin
            div_a = rsub[DW-1:0];
            div_b = {b_q[DW-2:0], 1'b1};
        end else begin
            div_a = rsh[DW-1:0];
            div_b = {b_q[DW-2:0], 1'b0};
        end
    end

    assign quo = neg_q  ? -div_b : div_b;
    assign rem = rneg_q ? -div_a : div_a;

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul)                          state_d = MUL;
                    else if (is_div && operand2 != '0)   state_d = DIV;
                end
            end
            MUL, DIV: if (last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            hi       <= '0;
            lo       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            cnt_q  <= '0;
                            a_q    <= '0;
                            b_q    <= mag(operand2, is_sgn);
                            m_q    <= mag(operand1, is_sgn);
                            neg_q  <= is_sgn && (operand1[DW-1] ^ operand2[DW-1]);
                            rneg_q <= 1'b0;
                            ovf_q  <= 1'b0;
                        end else if (is_div && operand2 == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            lo       <= '1;
                            hi       <= operand1;
                            result   <= '1;
                            zero     <= 1'b0;
                            overflow <= 1'b0;
                        end else if (is_div) begin
                            cnt_q  <= '0;
                            a_q    <= '0;
                            b_q    <= mag(operand1, is_sgn);
                            m_q    <= mag(operand2, is_sgn);
                            neg_q  <= is_sgn && (operand1[DW-1] ^ operand2[DW-1]);
                            rneg_q <= is_sgn && operand1[DW-1];
                            ovf_q  <= is_sgn && (operand1 == MOST_NEG) && (operand2 == '1);
                        end else begin
                            done     <= 1'b1;
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            div_zero <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    a_q   <= mul_a;
                    b_q   <= mul_b;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        done     <= 1'b1;
                        hi       <= prod[2*DW-1:DW];
                        lo       <= prod[DW-1:0];
                        result   <= prod[DW-1:0];
                        zero     <= (prod[DW-1:0] == '0);
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                    end
                end
                DIV: begin
                    a_q   <= div_a;
                    b_q   <= div_b;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        done     <= 1'b1;
                        hi       <= rem;
                        lo       <= quo;
                        result   <= quo;
                        zero     <= (quo == '0);
                        overflow <= ovf_q;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op_sel = '0;
    logic [31:0] operand1 = '0, operand2 = '0;
    logic        busy, done, zero, overflow, div_zero;
    logic [31:0] result, hi, lo;

    int errs = 0;
    int nchk = 0;

    alu_muldiv #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
        .operand1(operand1), .operand2(operand2), .busy(busy), .done(done),
        .result(result), .hi(hi), .lo(lo), .zero(zero), .overflow(overflow),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at the negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op_sel = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // {busy,done,zero,overflow,div_zero}
    function automatic logic [4:0] flags();
        return {busy, done, zero, overflow, div_zero};
    endfunction

    task automatic chk_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input logic [4:0] exp_fl);
        issue(op, a, b);
        chk({tag, "_res"}, 64'(result), 64'(exp_res));
        chk({tag, "_flags"}, 64'(flags()), 64'(exp_fl));
    endtask

    task automatic chk_iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_ovf);
        int cyc;
        issue(op, a, b);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'd32);
        chk({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        chk({tag, "_res"}, 64'(result), 64'(exp_lo));
        chk({tag, "_flags"}, 64'(flags()), 64'({1'b0, 1'b1, exp_lo == 32'd0, exp_ovf, 1'b0}));
    endtask

    initial begin
        int cyc;
        int seen;

        // Reset state
        #12;
        chk("rst_flags", 64'(flags()), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // First start right after reset release, then back-to-back single-cycle ops
        chk_alu("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010);
        @(posedge clk); #1;
        chk("add_hold_done", 64'(done), 64'd0);
        chk("add_hold_res", 64'(result), 64'h8000_0000);
        chk_alu("sub_ovf", 4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b01010);
        chk_alu("sub_zero", 4'b0001, 32'd5, 32'd5, 32'd0, 5'b01100);
        chk_alu("and", 4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 5'b01000);
        chk_alu("or",  4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 5'b01000);
        chk_alu("xor", 4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 5'b01000);
        chk_alu("nor", 4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 5'b01000);
        chk_alu("slt_t", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 5'b01000);
        chk_alu("slt_f", 4'b0100, 32'd3, 32'd2, 32'd0, 5'b01100);
        chk_alu("sgt_f", 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'b01100);
        chk_alu("sgt_t", 4'b1001, 32'd1, 32'h8000_0000, 32'd1, 5'b01000);
        chk_alu("sll_mod", 4'b0111, 32'd36, 32'h8000_000F, 32'h0000_00F0, 5'b01000);
        chk_alu("srl", 4'b1000, 32'd4, 32'h8000_0000, 32'h0800_0000, 5'b01000);

        // Multiply / divide
        chk_iter("mult", 4'b1010, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        chk_iter("multu", 4'b1011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        chk_iter("divu", 4'b1101, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        chk_iter("div_nn", 4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        chk_iter("div_pn", 4'b1100, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

        // Divide by zero completes in one cycle
        issue(4'b1100, 32'd5, 32'd0);
        chk("dz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        chk("dz_res", 64'(result), 64'hFFFF_FFFF);
        chk("dz_flags", 64'(flags()), 64'b01001);

        chk_iter("div_ovf", 4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);

        // Undefined opcode: result 0, zero 1, hi/lo untouched
        chk_alu("undef", 4'b1110, 32'd9, 32'd9, 32'd0, 5'b01100);
        chk("undef_hilo", {hi, lo}, {32'd0, 32'h8000_0000});

        // Start while busy is ignored; operand changes while busy ignored
        issue(4'b1011, 32'd6, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        issue(4'b0000, 32'd1, 32'd1);
        chk("ign_busy", 64'(busy), 64'd1);
        chk("ign_done", 64'(done), 64'd0);
        chk("ign_res", 64'(result), 64'd0);
        wait_done(cyc);
        chk("ign_lat", 64'(cyc), 64'd27);
        chk("ign_hilo", {hi, lo}, {32'd0, 32'd42});
        chk("ign_res2", 64'(result), 64'd42);

        // Reset in the middle of a multiply aborts without a done pulse
        issue(4'b1011, 32'd3, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk); rst_n = 1'b0; #1;
        chk("abort_flags", 64'(flags()), 64'd0);
        chk("abort_res", 64'(result), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
        chk("abort_no_done", 64'(seen), 64'd0);

        chk_alu("post_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 5'b01000);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
